// File: rtl/gate_sweep_checker.sv
// Exhaustive 2-input gate checker: sweeps {a,b} through 00..11, samples y after
// SETTLE cycles per vector and compares each sample against the EXPECT truth table.
module gate_sweep_checker #(
    parameter int unsigned SETTLE = 2,
    parameter logic [3:0]  EXPECT = 4'b0111
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start,
    input  logic       i_y,
    output logic       o_a,
    output logic       o_b,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_pass,
    output logic [3:0] o_err_mask,
    output logic [1:0] o_vec_idx
);
    localparam int unsigned CNT_W = 8;
    localparam int unsigned VEC_W = 2;
    localparam int unsigned NVEC  = 4;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);
    localparam logic [VEC_W-1:0] VEC_LAST = VEC_W'(NVEC - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           r_state, w_state;
    logic [CNT_W-1:0] r_cnt, w_cnt;
    logic [VEC_W-1:0] r_vec, w_vec;
    logic [NVEC-1:0]  r_err, w_err;
    logic             r_pass, w_pass;
    logic             r_done, w_done;
    logic             r_busy, w_busy;
    logic             r_a, w_a;
    logic             r_b, w_b;
    logic             w_match;

    // X/Z on y leaves w_match unknown, which falls into the mismatch branch below
    assign w_match = (i_y == EXPECT[r_vec]);

    // Next-state and next-output logic
    always_comb begin
        w_state = r_state;
        w_cnt   = r_cnt;
        w_vec   = r_vec;
        w_err   = r_err;
        w_pass  = r_pass;
        w_done  = 1'b0;
        w_busy  = r_busy;
        w_a     = r_a;
        w_b     = r_b;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_state = ST_WAIT;
                    w_cnt   = '0;
                    w_vec   = '0;
                    w_err   = '0;
                    w_pass  = 1'b0;
                    w_busy  = 1'b1;
                    w_a     = 1'b0;
                    w_b     = 1'b0;
                end
            end
            ST_WAIT: begin
                w_cnt = r_cnt + CNT_W'(1);
                if (r_cnt == CNT_LAST) begin
                    if (w_match) begin
                        w_err = r_err;
                    end else begin
                        w_err = r_err | (NVEC'(1) << r_vec);
                    end
                    w_cnt = '0;
                    if (r_vec == VEC_LAST) begin
                        w_state = ST_DONE;
                        w_done  = 1'b1;
                        w_busy  = 1'b0;
                        w_pass  = (w_err == '0);
                        w_vec   = '0;
                        w_a     = 1'b0;
                        w_b     = 1'b0;
                    end else begin
                        w_vec      = r_vec + VEC_W'(1);
                        {w_a, w_b} = w_vec;
                    end
                end
            end
            ST_DONE: begin
                w_state = ST_IDLE;
            end
            default: begin
                w_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_vec   <= '0;
            r_err   <= '0;
            r_pass  <= 1'b0;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
            r_a     <= 1'b0;
            r_b     <= 1'b0;
        end else begin
            r_state <= w_state;
            r_cnt   <= w_cnt;
            r_vec   <= w_vec;
            r_err   <= w_err;
            r_pass  <= w_pass;
            r_done  <= w_done;
            r_busy  <= w_busy;
            r_a     <= w_a;
            r_b     <= w_b;
        end
    end

    assign o_a        = r_a;
    assign o_b        = r_b;
    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_pass     = r_pass;
    assign o_err_mask = r_err;
    assign o_vec_idx  = r_vec;

endmodule
